// File: rtl/uart_rx_bit_timer.sv
// Oversampling edge/bit timer for the UART receive path.
// Runtime prescale and frame format are latched at frame start; all strobes decode registered counts.
module uart_rx_bit_timer #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4,
    parameter int FRAME_MAX  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cnt_en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [1:0]            data_bits,
    input  logic                  par_en,
    input  logic                  stop2,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  sample_stb,
    output logic                  mid_stb,
    output logic                  bit_done,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  cfg_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    logic [1:0]            state;
    logic [PRESCALE_W-1:0] p_lat;
    logic [BIT_CNT_W-1:0]  n_last_lat;
    logic [BIT_CNT_W:0]    n_sum;
    logic [BIT_CNT_W:0]    n_cfg;
    logic [BIT_CNT_W-1:0]  n_last_cfg;
    logic                  prescale_ok;
    logic [PRESCALE_W-1:0] half;

    always_comb begin
        prescale_ok = (prescale[0] == 1'b0)
                   && (prescale >= PRESCALE_W'(4))
                   && (prescale <= PRESCALE_W'(32));
        n_sum = (BIT_CNT_W+1)'(7) + (BIT_CNT_W+1)'(data_bits)
              + (BIT_CNT_W+1)'(par_en) + (BIT_CNT_W+1)'(stop2);
        n_cfg = (n_sum > (BIT_CNT_W+1)'(FRAME_MAX)) ? (BIT_CNT_W+1)'(FRAME_MAX) : n_sum;
        n_cfg = n_cfg - (BIT_CNT_W+1)'(1);
        n_last_cfg = n_cfg[BIT_CNT_W-1:0];
    end

    // Frame length is stored as the index of its last bit, N-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            cfg_err    <= 1'b0;
            p_lat      <= '0;
            n_last_lat <= '0;
        end else if (!cnt_en) begin
            state    <= ST_IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            cfg_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (prescale_ok) begin
                        state      <= ST_COUNT;
                        edge_cnt   <= PRESCALE_W'(1);
                        bit_cnt    <= '0;
                        p_lat      <= prescale;
                        n_last_lat <= n_last_cfg;
                    end else begin
                        state   <= ST_ERR;
                        cfg_err <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (edge_cnt < p_lat) begin
                        edge_cnt <= edge_cnt + PRESCALE_W'(1);
                    end else if (bit_cnt < n_last_lat) begin
                        bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                        edge_cnt <= PRESCALE_W'(1);
                    end else begin
                        state    <= ST_HOLD;
                        edge_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                ST_HOLD: begin
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                end
                default: begin
                    cfg_err <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        half       = {1'b0, p_lat[PRESCALE_W-1:1]};
        busy       = (state == ST_COUNT);
        sample_stb = busy && ((edge_cnt == half - PRESCALE_W'(1))
                           || (edge_cnt == half)
                           || (edge_cnt == half + PRESCALE_W'(1)));
        mid_stb    = busy && (edge_cnt == half);
        bit_done   = busy && (edge_cnt == p_lat);
        frame_done = bit_done && (bit_cnt == n_last_lat);
    end

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Self-checking bench for uart_rx_bit_timer: directed test-plan cases plus randomized segments,
// all checked every cycle against a frame-position model (cycle index k within the frame).
module tb_uart_rx_bit_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cnt_en;
    logic [5:0] prescale;
    logic [1:0] data_bits;
    logic       par_en;
    logic       stop2;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sample_stb, mid_stb, bit_done, frame_done, busy, cfg_err;

    uart_rx_bit_timer #(.PRESCALE_W(6), .BIT_CNT_W(4), .FRAME_MAX(12)) dut (
        .clk(clk), .rst(rst), .cnt_en(cnt_en), .prescale(prescale),
        .data_bits(data_bits), .par_en(par_en), .stop2(stop2),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .sample_stb(sample_stb),
        .mid_stb(mid_stb), .bit_done(bit_done), .frame_done(frame_done),
        .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit legal(input int p);
        return (p % 2 == 0) && (p >= 4) && (p <= 32);
    endfunction

    // Model: mode 0 idle, 1 counting, 2 done-hold, 3 config error; k = cycles since frame start.
    int mode = 0;
    int k = 0;
    int mp = 0;
    int mn = 0;
    bit live = 0;

    always @(posedge clk) begin
        live = 1;
        if (rst || !cnt_en) begin
            mode = 0;
            k = 0;
        end else begin
            case (mode)
                0: begin
                    if (legal(int'(prescale))) begin
                        mode = 1;
                        k = 0;
                        mp = int'(prescale);
                        mn = 7 + int'(data_bits) + int'(par_en) + int'(stop2);
                    end else begin
                        mode = 3;
                    end
                end
                1: begin
                    k++;
                    if (k == mp * mn) begin
                        mode = 2;
                        k = 0;
                    end
                end
                default: ;
            endcase
        end
    end

    int e, b, h;
    logic [15:0] expv, actv;

    always @(negedge clk) begin
        if (live) begin
            if (mode == 1) begin
                e = k % mp + 1;
                b = k / mp;
            end else begin
                e = 0;
                b = 0;
            end
            h = mp / 2;
            expv = {6'(e), 4'(b),
                    (mode == 1) && (e >= h - 1) && (e <= h + 1),
                    (mode == 1) && (e == h),
                    (mode == 1) && (e == mp),
                    (mode == 1) && (k == mp * mn - 1),
                    (mode == 1),
                    (mode == 3)};
            actv = {edge_cnt, bit_cnt, sample_stb, mid_stb, bit_done, frame_done, busy, cfg_err};
            vectors++;
            if (actv !== expv) begin
                miscompares++;
                $display("FAIL cycle_outputs t=%0t: got edge=%0d bit=%0d smp/mid/bd/fd/busy/err=%b, expected edge=%0d bit=%0d smp/mid/bd/fd/busy/err=%b",
                         $time, actv[15:10], actv[9:6], actv[5:0], expv[15:10], expv[9:6], expv[5:0]);
            end
        end
    end

    task automatic start(input int p, input int db, input int pe, input int s2);
        prescale  = 6'(p);
        data_bits = 2'(db);
        par_en    = 1'(pe);
        stop2     = 1'(s2);
        cnt_en    = 1'b1;
    endtask

    task automatic stop_count;
        cnt_en = 1'b0;
        tick();
    endtask

    task automatic run_frame(input int chg_bit, output int cyc, output int bd, output int ss,
                             output int md, output int ok);
        cyc = 0; bd = 0; ss = 0; md = 0; ok = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (busy) cyc++;
            if (bit_done) bd++;
            if (sample_stb) ss++;
            if (mid_stb) md++;
            if (frame_done) begin
                ok = 1;
                break;
            end
            if (chg_bit >= 0 && int'(bit_cnt) == chg_bit) begin
                data_bits = 2'd3;
                par_en    = 1'b1;
            end
        end
        check("frame_done_seen", ok, 1);
    endtask

    int cyc, bd, ss, md, ok, len, p;
    int bad_p[3] = '{7, 2, 34};

    initial begin
        rst = 1'b1; cnt_en = 1'b0;
        prescale = 6'd8; data_bits = 2'd3; par_en = 1'b0; stop2 = 1'b0;
        repeat (3) tick();
        check("reset_outputs",
              int'({edge_cnt, bit_cnt, sample_stb, mid_stb, bit_done, frame_done, busy, cfg_err}), 0);
        rst = 1'b0;
        tick();

        // P=8, 8N1
        start(8, 3, 0, 0);
        run_frame(-1, cyc, bd, ss, md, ok);
        check("8n1_frame_cycles", cyc, 80);
        check("8n1_bit_done_count", bd, 10);
        check("8n1_sample_count", ss, 30);
        check("8n1_mid_count", md, 10);
        tick();
        check("8n1_hold_busy", int'(busy), 0);
        check("8n1_hold_edge", int'(edge_cnt), 0);
        tick();
        check("8n1_hold_no_restart", int'(busy), 0);
        stop_count();

        // P=16, 7 data, parity, 2 stop
        start(16, 2, 1, 1);
        run_frame(-1, cyc, bd, ss, md, ok);
        check("7e2_frame_cycles", cyc, 176);
        check("7e2_bit_done_count", bd, 11);
        check("7e2_sample_count", ss, 33);
        stop_count();

        // Abort mid-frame, then restart
        start(8, 3, 0, 0);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bit_cnt == 4'd3 && edge_cnt == 6'd5) begin
                ok = 1;
                break;
            end
        end
        check("abort_point_seen", ok, 1);
        cnt_en = 1'b0;
        tick();
        check("abort_edge", int'(edge_cnt), 0);
        check("abort_bit", int'(bit_cnt), 0);
        check("abort_busy", int'(busy), 0);
        cnt_en = 1'b1;
        tick();
        check("restart_edge", int'(edge_cnt), 1);
        check("restart_bit", int'(bit_cnt), 0);
        stop_count();

        // Illegal prescales
        foreach (bad_p[i]) begin
            start(bad_p[i], 3, 0, 0);
            tick();
            check("cfg_err_set", int'(cfg_err), 1);
            check("cfg_err_edge", int'(edge_cnt), 0);
            check("cfg_err_busy", int'(busy), 0);
            tick();
            check("cfg_err_held", int'(cfg_err), 1);
            stop_count();
            check("cfg_err_cleared", int'(cfg_err), 0);
        end
        start(8, 3, 0, 0);
        tick();
        check("legal_after_err_edge", int'(edge_cnt), 1);
        check("legal_after_err_busy", int'(busy), 1);
        stop_count();

        // Format change mid-frame is ignored
        start(8, 0, 0, 0);
        run_frame(2, cyc, bd, ss, md, ok);
        check("fmt_change_frame_cycles", cyc, 56);
        stop_count();

        // rst mid-frame with cnt_en high
        start(8, 3, 0, 0);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bit_cnt == 4'd4) begin
                ok = 1;
                break;
            end
        end
        check("rst_point_seen", ok, 1);
        rst = 1'b1;
        tick();
        check("rst_outputs",
              int'({edge_cnt, bit_cnt, sample_stb, mid_stb, bit_done, frame_done, busy, cfg_err}), 0);
        rst = 1'b0;
        tick();
        check("rst_resume_edge", int'(edge_cnt), 1);
        check("rst_resume_bit", int'(bit_cnt), 0);
        stop_count();

        // Randomized segments, checked by the per-cycle model
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 3) != 0) begin
                p = 2 * int'($urandom_range(2, 16));
            end else begin
                p = int'($urandom_range(0, 63));
                if (legal(p)) p = p | 1;
            end
            start(p, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            len = int'($urandom_range(1, 420));
            for (int i = 0; i < len; i++) begin
                tick();
                if ($urandom_range(0, 39) == 0) begin
                    prescale  = 6'($urandom_range(0, 63));
                    data_bits = 2'($urandom_range(0, 3));
                    par_en    = 1'($urandom_range(0, 1));
                    stop2     = 1'($urandom_range(0, 1));
                end
                rst = ($urandom_range(0, 299) == 0);
            end
            rst = 1'b0;
            cnt_en = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_bit_timer.md
Name: uart_rx_bit_timer

Overview:
Parametrised oversampling edge/bit timer for the UART receive path, the successor to the fixed-prescale edge/bit counter. It takes a runtime prescale and frame format (data bits, parity, stop bits), latched per frame. It produces edge and bit counts, majority-vote sample strobes, bit-done and frame-done pulses, and a configuration-error flag. It sits between the RX control FSM, which drives cnt_en, and the data sampler and deserializer.

Parameters:
PRESCALE_W, 6, width of prescale and edge_cnt; must hold the largest legal prescale (32).
BIT_CNT_W, 4, width of bit_cnt; must hold FRAME_MAX-1.
FRAME_MAX, 12, maximum frame length in bits (1 start + 8 data + 1 parity + 2 stop).

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
cnt_en  input  1  count enable from RX FSM; low = abort/idle
prescale  input  PRESCALE_W  oversampling ratio; legal values are even, 4..32
data_bits  input  2  0/1/2/3 = 5/6/7/8 data bits
par_en  input  1  parity bit present
stop2  input  1  two stop bits when high, else one
edge_cnt  output  PRESCALE_W  edge position within current bit, 1..P; 0 when not counting
bit_cnt  output  BIT_CNT_W  bit index within frame, 0 = start bit
sample_stb  output  1  high when edge_cnt is in {P/2-1, P/2, P/2+1}
mid_stb  output  1  high when edge_cnt == P/2
bit_done  output  1  high when edge_cnt == P in COUNT state
frame_done  output  1  high when edge_cnt == P and bit_cnt == N-1
busy  output  1  state == COUNT
cfg_err  output  1  illegal prescale seen at frame start

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). The polarity and synchronicity are fixed.
- Register types: state, edge_cnt, bit_cnt, cfg_err, P_lat and N_lat are registers. All strobes are combinational decodes of the registered state and counts, so they add no extra latency.
- Reset values: state = IDLE; edge_cnt, bit_cnt, cfg_err, busy and all strobes = 0.
- Frame length: N = 1 + (5 + data_bits) + par_en + (1 + stop2). The range is 7..12.
- IDLE:
  - cnt_en=1 with a legal prescale → COUNT. Next cycle edge_cnt=1 and bit_cnt=0. P_lat and N_lat are latched from the inputs in this cycle.
  - cnt_en=1 with an illegal prescale (odd, <4 or >32) → ERR. cfg_err=1 next cycle, and the counters stay at 0.
- COUNT:
  - edge_cnt < P_lat: edge_cnt+1.
  - edge_cnt == P_lat and bit_cnt < N_lat-1: bit_cnt+1, edge_cnt=1.
  - edge_cnt == P_lat and bit_cnt == N_lat-1: → HOLD. edge_cnt=0 and bit_cnt=0 next cycle.
- HOLD:
  - Counters stay at 0 and there is no auto-restart.
  - cnt_en=0 → IDLE.
- ERR:
  - cfg_err is held high.
  - cnt_en=0 → IDLE next cycle, with cfg_err=0.
- cnt_en=0 in any state: → IDLE next cycle, with edge_cnt=0, bit_cnt=0 and cfg_err=0. This applies mid-bit and mid-frame.
- rst: overrides cnt_en in any state.
- Config changes: changes to prescale, data_bits, par_en or stop2 while in COUNT are ignored. Only P_lat and N_lat are used until the frame ends.
- Frame timing: a frame lasts exactly P_lat*N_lat cycles, counted from the first cycle with edge_cnt=1.
- Coincident strobes:
  - bit_done and frame_done coincide on the last edge of the frame.
  - At P=4, sample_stb covers edges 1, 2 and 3, and never coincides with bit_done.
- Arithmetic: all comparisons are unsigned. P/2 is prescale shifted right by 1. edge_cnt never exceeds P_lat, and bit_cnt never exceeds N_lat-1.

Test Plan:
- P=8, 8N1 (N=10), cnt_en held high:
  - edge_cnt cycles 1..8 and bit_cnt steps 0..9.
  - sample_stb is high at edges 3, 4 and 5; mid_stb at edge 4.
  - frame_done fires on the 80th counting cycle; the block then enters HOLD with counters at 0.
- P=16, 7 data bits, parity, 2 stop (N=11):
  - frame_done fires at cycle 176.
  - sample_stb is high at edges 7, 8 and 9.
  - bit_done pulses 11 times.
- cnt_en dropped at bit_cnt=3, edge_cnt=5:
  - The next cycle shows edge_cnt=0, bit_cnt=0 and busy=0.
  - Re-asserting cnt_en restarts at edge_cnt=1, bit_cnt=0.
- prescale=7, 2 and 34, each followed by cnt_en=1:
  - cfg_err=1 next cycle and the counters stay at 0.
  - cnt_en=0 clears cfg_err next cycle.
  - A subsequent legal prescale=8 counts normally.
- Format change mid-frame: start 5N1 (N=7, P=8), then switch data_bits=3 and par_en=1 at bit 2 → frame_done still fires at cycle 56.
- rst pulsed at bit 4 with cnt_en still high:
  - All outputs are 0 the next cycle.
  - After rst is released, with cnt_en still high, counting resumes at edge_cnt=1, bit_cnt=0 one cycle later.
